// File: rtl/key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
//
// Push-button debouncer for an active-low key. The raw pin is synchronised to
// Clk50M. A press or a release is confirmed only after the synchronised level
// has held steady for CNT_MAX+1 cycles (20 ms at 50 MHz with the default).
// Each confirmation produces a one-cycle key_flag pulse. key_state is updated
// in the same cycle.
//
// Parameters
//   CNT_MAX   stable window length minus one, in Clk50M cycles
//   CNT_W     filter counter width; 2**CNT_W must exceed CNT_MAX
//
// Ports
//   Clk50M     in   system clock, 50 MHz
//   Rst        in   synchronous active-high reset
//   key_in     in   raw key pin, asynchronous (0 = pressed, 1 = released)
//   key_flag   out  one-cycle pulse on each confirmed press or release
//   key_state  out  debounced level (0 = pressed, 1 = released)
//
// Timing: a key_in change just before edge k enters the filter at edge k+2.
// It is confirmed at edge k+CNT_MAX+3. Both outputs are registered.
// -----------------------------------------------------------------------------
module key_filter #(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic Clk50M,
    input  logic Rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,  // released, stable
        FILTER_DOWN = 2'd1,  // fall seen, waiting out the window
        DOWN        = 2'd2,  // pressed, stable
        FILTER_UP   = 2'd3   // rise seen, waiting out the window
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Synchroniser plus history flop.
    // All three flops reset to the released level. A key that is held down
    // through reset then shows up as a fresh fall, not as a phantom edge.
    // -------------------------------------------------------------------------
    logic s0;
    logic s1;
    logic s2;
    logic fall;
    logic rise;

    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge values; with = the chain would collapse into a single flop.
    always_ff @(posedge Clk50M) begin
        if (Rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s0 <= key_in;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign fall = ~s1 &  s2;
    assign rise =  s1 & ~s2;

    // -------------------------------------------------------------------------
    // Filter FSM
    // -------------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             flag_nxt;
    logic             level_nxt;

    always_ff @(posedge Clk50M) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= CNT_ZERO;
            key_flag  <= 1'b0;
            key_state <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_flag  <= flag_nxt;
            key_state <= level_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case. A
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = CNT_ZERO;
        flag_nxt  = 1'b0;
        level_nxt = key_state;

        unique case (state)
            IDLE: begin
                // A rise here is only the tail of an aborted press, so it is ignored.
                if (fall) begin
                    state_nxt = FILTER_DOWN;
                end
            end

            FILTER_DOWN: begin
                // The opposite edge is tested first. When it arrives in the
                // same cycle the window expires, the press is still rejected.
                if (rise) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DOWN;
                    flag_nxt  = 1'b1;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            DOWN: begin
                if (rise) begin
                    state_nxt = FILTER_UP;
                end
            end

            FILTER_UP: begin
                if (fall) begin
                    state_nxt = DOWN;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    flag_nxt  = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Invariants. Synthesis ignores these; simulation checks them.
    // -------------------------------------------------------------------------
    a_cnt_bounded : assert property (
        @(posedge Clk50M) disable iff (Rst) cnt <= CNT_LAST
    );

    a_cnt_idle_zero : assert property (
        @(posedge Clk50M) disable iff (Rst)
        (state == IDLE || state == DOWN) |-> (cnt == CNT_ZERO)
    );

    a_flag_single : assert property (
        @(posedge Clk50M) disable iff (Rst) key_flag |=> !key_flag
    );

    a_level_matches_state : assert property (
        @(posedge Clk50M) disable iff (Rst)
        (state == IDLE || state == FILTER_DOWN) |-> key_state
    );

endmodule
